// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: reset PC, HALT opcode decode, FSM states, buffer entry.
// No logic of its own; imported by instr_fetch and fetch_buf.
package instr_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          BUF_ENTRIES      = 2;

  // 1LD major-opcode code for System|Branch, and the HALT qualifier bit positions
  localparam logic [1:0]  OPC_SYS_BR   = 2'b11;
  localparam int          HALT_OPC_HI  = 31;
  localparam int          HALT_OPC_LO  = 30;
  localparam int          HALT_SET_BIT = 28;
  localparam int          HALT_CLR_BIT = 27;
  localparam int          HALT_FN_HI   = 28;
  localparam int          HALT_FN_LO   = 25;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [31:0] w);
    logic [3:0] fn;
    fn = w[HALT_FN_HI:HALT_FN_LO];
    return (w[HALT_OPC_HI:HALT_OPC_LO] == OPC_SYS_BR) && w[HALT_SET_BIT] && !w[HALT_CLR_BIT]
           && !(fn inside {4'b0000, 4'b0001, 4'b0010});
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, instr}; head is registered, visible the cycle after push.
// Push when full is accepted only alongside a pop; clear overrides push and pop.
module fetch_buf
  import instr_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  output fetch_entry_t head_dat,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [BUF_ENTRIES];
  fetch_entry_t mem_d [BUF_ENTRIES];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (clear) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited requests, in-order tagging, redirect flush, HALT stop.
// Response reaches decode 1 cycle later; stall holds the head and throttles new requests.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] Instruction,
  output logic [31:0] instr_pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

  state_e       state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   outst_q, outst_d;
  logic [1:0]   drop_q, drop_d;
  logic [31:0]  tag_q [2];
  logic [31:0]  tag_d [2];
  logic         tag_wr_q, tag_wr_d;
  logic         tag_rd_q, tag_rd_d;
  logic         halted_q, halted_d;

  logic         hs, rsp, pop, redir;
  logic         buf_push, buf_clear, buf_full, buf_empty;
  logic [1:0]   buf_count;
  logic [2:0]   occ;
  logic [31:0]  redir_pc;
  fetch_entry_t buf_head, buf_in;

  // A same-cycle pop frees a slot, so it counts as a credit; this sustains one fetch per cycle
  assign occ         = {1'b0, outst_q} + {1'b0, buf_count};
  assign imem_req    = rst_n && (state_q == ST_RUN) && (occ < DEPTH + {2'b00, pop});
  assign imem_addr   = pc_q;
  assign instr_valid = !buf_empty && (state_q != ST_HALTED);
  assign Instruction = buf_head.instr;
  assign instr_pc    = buf_head.pc;
  assign halted      = halted_q;

  assign pop      = instr_valid && !stall;
  assign hs       = imem_req && imem_ready;
  assign rsp      = imem_rvalid && (outst_q != 2'd0);
  assign redir    = redirect_valid && (state_q != ST_HALTED);
  assign redir_pc = {redirect_pc[31:2], 2'b00};
  assign buf_in   = '{pc: tag_q[tag_rd_q], instr: imem_rdata};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    tag_d     = tag_q;
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    buf_push  = 1'b0;
    buf_clear = 1'b0;
    outst_d   = outst_q + {1'b0, hs} - {1'b0, rsp};
    unique case (state_q)
      ST_RUN: begin
        if (redir) begin
          buf_clear = 1'b1;
          tag_wr_d  = 1'b0;
          tag_rd_d  = 1'b0;
          pc_d      = redir_pc;
          drop_d    = outst_d;
          if (outst_d != 2'd0) state_d = ST_FLUSH;
        end else begin
          if (hs) begin
            tag_d[tag_wr_q] = pc_q;
            tag_wr_d        = ~tag_wr_q;
            pc_d            = pc_q + 32'd4;
          end
          if (rsp) begin
            buf_push = !buf_full || pop;
            tag_rd_d = ~tag_rd_q;
          end
          if (pop && is_halt(buf_head.instr)) state_d = ST_HALTED;
        end
      end
      ST_FLUSH: begin
        if (redir) pc_d = redir_pc;
        if (rsp && (drop_q != 2'd0)) drop_d = drop_q - 2'd1;
        if (drop_d == 2'd0) state_d = ST_RUN;
      end
      default: begin
      end
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= {RESET_PC[31:2], 2'b00};
      outst_q  <= 2'd0;
      drop_q   <= 2'd0;
      tag_q    <= '{default: '0};
      tag_wr_q <= 1'b0;
      tag_rd_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      tag_q    <= tag_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      halted_q <= halted_d;
    end
  end

  fetch_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (buf_clear),
    .push     (buf_push),
    .push_dat (buf_in),
    .pop      (pop),
    .head_dat (buf_head),
    .full     (buf_full),
    .empty    (buf_empty),
    .count    (buf_count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model with settable latency, streaming vector table,
// and hand sequences for redirect flush, HALT, HALT-vs-redirect and PC wrap.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, stall, redirect_valid, halted;
  logic [31:0] Instruction, instr_pc, redirect_pc;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .Instruction    (Instruction),
    .instr_pc       (instr_pc),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          lat   = 1;
  logic [31:0] halt_addr = 32'h0000_0001;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend_q[$];

  typedef struct {
    logic        st;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;
  vec_t vecs[14];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == halt_addr) return 32'hD000_0000;
    return {8'h13, a[23:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rdy, input logic rv, input logic [31:0] rpc);
    stall          = st;
    imem_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #2;
  endtask

  // One clock: capture the handshake, then present memory responses in order
  task automatic step();
    logic        h;
    logic [31:0] a;
    h = imem_req & imem_ready;
    a = imem_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) pend_q.delete();
    else if (h) pend_q.push_back('{a, cyc + lat - 1});
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
    end
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    chk({nm, "_rst_req"}, 32'(imem_req), 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    chk({nm, "_rst_iv"},     32'(instr_valid), 32'd0);
    chk({nm, "_rst_halted"}, 32'(halted),      32'd0);
    chk({nm, "_rst_instr"},  Instruction,      32'd0);
    chk({nm, "_rst_pc"},     instr_pc,         32'd0);
  endtask

  task automatic wait_iv(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      if (instr_valid) ok = 1'b1;
      else begin
        step();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

    // {stall, imem_req, imem_addr, instr_valid, instr_pc}; latency 1, ready=1
    vecs[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
    vecs[1]  = '{1'b0, 1'b1, 32'd4,  1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
    vecs[3]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd4};
    vecs[4]  = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd8};
    vecs[5]  = '{1'b1, 1'b0, 32'd20, 1'b1, 32'd12};
    vecs[6]  = '{1'b1, 1'b0, 32'd20, 1'b1, 32'd12};
    vecs[7]  = '{1'b1, 1'b0, 32'd20, 1'b1, 32'd12};
    vecs[8]  = '{1'b1, 1'b0, 32'd20, 1'b1, 32'd12};
    vecs[9]  = '{1'b1, 1'b0, 32'd20, 1'b1, 32'd12};
    vecs[10] = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd12};
    vecs[11] = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd16};
    vecs[12] = '{1'b0, 1'b1, 32'd28, 1'b1, 32'd20};
    vecs[13] = '{1'b0, 1'b1, 32'd32, 1'b1, 32'd24};

    do_reset("stream");
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].st, 1'b1, 1'b0, 32'd0);
      chk($sformatf("v%0d_req", i),   32'(imem_req),    32'(vecs[i].req));
      chk($sformatf("v%0d_addr", i),  imem_addr,        vecs[i].addr);
      chk($sformatf("v%0d_iv", i),    32'(instr_valid), 32'(vecs[i].iv));
      chk($sformatf("v%0d_pc", i),    instr_pc,         vecs[i].pc);
      chk($sformatf("v%0d_instr", i), Instruction,      vecs[i].iv ? mem_data(vecs[i].pc) : 32'd0);
      chk($sformatf("v%0d_halt", i),  32'(halted),      32'd0);
      step();
    end

    // Redirect with two requests in flight (latency 3)
    do_reset("redir");
    lat = 3;
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("redir_c0_addr", imem_addr, 32'd0);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("redir_c1_req", 32'(imem_req), 32'd1);
    chk("redir_c1_addr", imem_addr, 32'd4);
    step();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    chk("redir_c2_req", 32'(imem_req), 32'd0);
    step();
    for (int k = 3; k <= 4; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0);
      chk($sformatf("redir_c%0d_req", k), 32'(imem_req), 32'd0);
      chk($sformatf("redir_c%0d_iv", k), 32'(instr_valid), 32'd0);
      chk($sformatf("redir_c%0d_addr", k), imem_addr, 32'h100);
      step();
    end
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("redir_c5_req", 32'(imem_req), 32'd1);
    chk("redir_c5_addr", imem_addr, 32'h100);
    wait_iv("redir_wait_iv");
    chk("redir_pc", instr_pc, 32'h100);
    chk("redir_instr", Instruction, mem_data(32'h100));
    lat = 1;

    // HALT popped at address 8
    do_reset("halt");
    halt_addr = 32'd8;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0);
      step();
    end
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("halt_head_pc", instr_pc, 32'd8);
    chk("halt_head_instr", Instruction, 32'hD000_0000);
    chk("halt_pre", 32'(halted), 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, (k == 1), 32'h40);
      chk($sformatf("halt_h%0d_halted", k), 32'(halted), 32'd1);
      chk($sformatf("halt_h%0d_req", k), 32'(imem_req), 32'd0);
      chk($sformatf("halt_h%0d_iv", k), 32'(instr_valid), 32'd0);
      step();
    end
    do_reset("halt_exit");

    // Redirect in the same cycle HALT is popped: redirect wins
    do_reset("hredir");
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0);
      step();
    end
    drive(1'b0, 1'b1, 1'b1, 32'h200);
    chk("hredir_head", Instruction, 32'hD000_0000);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("hredir_halted", 32'(halted), 32'd0);
    chk("hredir_flush_req", 32'(imem_req), 32'd0);
    wait_iv("hredir_wait_iv");
    chk("hredir_pc", instr_pc, 32'h200);
    chk("hredir_halted2", 32'(halted), 32'd0);
    halt_addr = 32'h0000_0001;

    // PC wrap at the top of the address space
    do_reset("wrap");
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    chk("wrap_c0_addr", imem_addr, 32'd0);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("wrap_c1_req", 32'(imem_req), 32'd1);
    chk("wrap_c1_addr", imem_addr, 32'hFFFF_FFF8);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("wrap_c2_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("wrap_c3_addr", imem_addr, 32'd0);
    chk("wrap_c3_pc", instr_pc, 32'hFFFF_FFF8);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("wrap_c4_addr", imem_addr, 32'd4);
    chk("wrap_c4_pc", instr_pc, 32'hFFFF_FFFC);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("wrap_c5_pc", instr_pc, 32'd0);
    chk("wrap_c5_instr", Instruction, mem_data(32'd0));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
